// File: rtl/periph_timer_pkg.sv
// periph_timer shared definitions: register map, field positions, FSM states.
package periph_timer_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned PRESCALE_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_LOAD   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_AUTO_BIT     = 1;
    localparam int unsigned CTRL_IE_BIT       = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;
    localparam int unsigned CTRL_PRESCALE_MSB = 15;

    localparam int unsigned STATUS_EXPIRED_BIT = 0;
    localparam int unsigned STATUS_RUNNING_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/periph_timer_prescaler.sv
// Tick divider: asserts tick when the count reaches divisor, then restarts.
module periph_timer_prescaler
    import periph_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] divisor,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;

    assign tick = (cnt_q == divisor);

    // Divider counter; clear restarts the period from zero.
    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped down-counting timer with one-shot/auto-reload and level irq.
// Optional prescaler enabled by defining PERIPH_TIMER_PRESCALE_EN.
module periph_timer
    import periph_timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              CE,
    input  logic              PWE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic                auto_q, auto_d;
    logic                ie_q, ie_d;
    logic                expired_q, expired_d;
    logic [DATA_W-1:0]   load_q, load_d;
    logic [DATA_W-1:0]   count_q, count_d;
    logic [PRESCALE_W-1:0] prescale_rd_c;
    logic                tick_c;
    logic                wr_c;
    logic                start_c;

    assign wr_c    = CE && PWE;
    assign start_c = wr_c && (addr == ADDR_CTRL) && wdata[CTRL_EN_BIT] && !en_q;

`ifdef PERIPH_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  presc_clear_c;

    // Divider only runs while counting and restarts on every enable.
    assign presc_clear_c = (state_q != ST_RUN) || start_c;
    assign prescale_rd_c = prescale_q;

    periph_timer_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear   (presc_clear_c),
        .divisor (prescale_q),
        .tick    (tick_c)
    );

    // Prescale field register.
    always_ff @(posedge clk) begin
        if (reset) prescale_q <= '0;
        else       prescale_q <= prescale_d;
    end

    // Prescale field is written by any CTRL store.
    always_comb begin
        prescale_d = prescale_q;
        if (wr_c && (addr == ADDR_CTRL)) begin
            prescale_d = wdata[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
        end
    end
`else
    assign tick_c        = 1'b1;
    assign prescale_rd_c = '0;
`endif

    // State and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            expired_q <= 1'b0;
            load_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            expired_q <= expired_d;
            load_q    <= load_d;
            count_q   <= count_d;
        end
    end

    // Next-state: bus writes, countdown and expiry; expiry beats W1C, COUNT write beats all.
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        auto_d    = auto_q;
        ie_d      = ie_q;
        expired_d = expired_q;
        load_d    = load_q;
        count_d   = count_q;

        if (wr_c && (addr == ADDR_CTRL)) begin
            auto_d = wdata[CTRL_AUTO_BIT];
            ie_d   = wdata[CTRL_IE_BIT];
        end
        if (wr_c && (addr == ADDR_LOAD)) begin
            load_d = wdata;
        end
        if (wr_c && (addr == ADDR_STATUS) && wdata[STATUS_EXPIRED_BIT]) begin
            expired_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_c) begin
                    state_d = ST_RUN;
                    en_d    = 1'b1;
                    count_d = load_q;
                end
            end
            ST_RUN: begin
                if (wr_c && (addr == ADDR_CTRL) && !wdata[CTRL_EN_BIT]) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                end else if (tick_c) begin
                    if (count_q == DATA_W'(0)) begin
                        expired_d = 1'b1;
                        en_d      = 1'b0;
                        state_d   = ST_DONE;
                    end else if (count_q == DATA_W'(1)) begin
                        expired_d = 1'b1;
                        if (auto_q) begin
                            count_d = load_q;
                        end else begin
                            count_d = '0;
                            en_d    = 1'b0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_q - DATA_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase

        if (wr_c && (addr == ADDR_COUNT)) begin
            count_d = wdata;
        end
    end

    // Zero-latency read mux, gated by chip enable.
    always_comb begin
        rdata = '0;
        if (CE) begin
            case (addr)
                ADDR_CTRL:   rdata = {16'b0, prescale_rd_c, 5'b0, ie_q, auto_q, en_q};
                ADDR_LOAD:   rdata = load_q;
                ADDR_COUNT:  rdata = count_q;
                ADDR_STATUS: rdata = {30'b0, (state_q == ST_RUN), expired_q};
                default:     rdata = '0;
            endcase
        end
    end

    assign irq = expired_q & ie_q;

endmodule

// File: tb/tb_periph_timer.sv
// Directed self-checking bench for periph_timer.
`timescale 1ns/1ps
module tb_periph_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        CE;
    logic        PWE;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    periph_timer dut (
        .clk   (clk),
        .reset (reset),
        .CE    (CE),
        .PWE   (PWE),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one rising edge; return 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        CE = 1'b1; PWE = 1'b1; addr = a; wdata = d;
        cyc();
        CE = 1'b0; PWE = 1'b0; wdata = '0;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        CE = 1'b1; PWE = 1'b0; addr = a;
        #1;
        d = rdata;
        CE = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        reset = 1'b1; CE = 1'b0; PWE = 1'b0; addr = '0; wdata = '0;
        cyc(); cyc();
        reset = 1'b0;

        // Reset state
        chk_rd("rst_ctrl",   2'd0, 32'h0);
        chk_rd("rst_load",   2'd1, 32'h0);
        chk_rd("rst_count",  2'd2, 32'h0);
        chk_rd("rst_status", 2'd3, 32'h0);
        chk_irq("rst_irq", 1'b0);
        CE = 1'b0; addr = 2'd1; #1;
        chk("rst_ce0", rdata, 32'h0);

        // One-shot, LOAD=5, EN|IE
        wr(2'd1, 32'd5);
        chk_rd("os_load", 2'd1, 32'd5);
        wr(2'd0, 32'h5);
        chk_rd("os_count_start", 2'd2, 32'd5);
        chk_rd("os_running", 2'd3, 32'h2);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk_rd($sformatf("os_count_%0d", i), 2'd2, 32'(5 - i));
            chk_irq($sformatf("os_irq_low_%0d", i), 1'b0);
        end
        cyc();
        chk_rd("os_status_exp", 2'd3, 32'h1);
        chk_irq("os_irq_high", 1'b1);
        chk_rd("os_ctrl_en0", 2'd0, 32'h4);
        chk_rd("os_count0", 2'd2, 32'h0);
        CE = 1'b0; addr = 2'd0; #1;
        chk("os_ce0", rdata, 32'h0);
        cyc();
        chk_rd("os_status_sticky", 2'd3, 32'h1);
        wr(2'd3, 32'h1);
        chk_rd("os_w1c", 2'd3, 32'h0);
        chk_irq("os_irq_clr", 1'b0);

        // Auto-reload, LOAD=3, EN|AUTO
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h3);                 // edge N
        cyc(); cyc();
        chk_rd("ar_count_1", 2'd2, 32'd1);
        chk_rd("ar_status_pre", 2'd3, 32'h2);
        cyc();                           // N+3
        chk_rd("ar_exp1", 2'd3, 32'h3);
        chk_rd("ar_reload1", 2'd2, 32'd3);
        chk_irq("ar_irq_ie0", 1'b0);
        wr(2'd3, 32'h1);                 // N+4
        chk_rd("ar_w1c", 2'd3, 32'h2);
        cyc(); cyc();                    // N+6
        chk_rd("ar_exp2", 2'd3, 32'h3);
        chk_rd("ar_reload2", 2'd2, 32'd3);

        // W1C on the expiry edge: set wins
        wr(2'd3, 32'h1);                 // N+7
        chk_rd("col_w1c_pre", 2'd3, 32'h2);
        cyc();                           // N+8
        wr(2'd3, 32'h1);                 // N+9 expiry
        chk_rd("col_w1c_setwins", 2'd3, 32'h3);

        // COUNT write on a tick edge
        wr(2'd2, 32'd10);
        chk_rd("col_count_wr", 2'd2, 32'd10);
        cyc(); cyc(); cyc();
        chk_rd("col_count_7", 2'd2, 32'd7);
        wr(2'd0, 32'h0);
        chk_rd("col_dis_hold", 2'd2, 32'd7);
        chk_rd("col_dis_status", 2'd3, 32'h1);
        cyc();
        chk_rd("col_dis_hold2", 2'd2, 32'd7);
        wr(2'd0, 32'h1);
        chk_rd("col_reen_reload", 2'd2, 32'd3);
        chk_rd("col_reen_run", 2'd3, 32'h3);
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h1);

        // LOAD=0 with AUTO: expires after one tick, goes DONE
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h3);
        chk_rd("z_run", 2'd3, 32'h2);
        cyc();
        chk_rd("z_status", 2'd3, 32'h1);
        chk_rd("z_ctrl", 2'd0, 32'h2);
        chk_rd("z_count", 2'd2, 32'h0);
        wr(2'd3, 32'h1);

        // Reset mid-count
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h5);
        cyc(); cyc();
        chk_rd("mr_count2", 2'd2, 32'd2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_rd("mr_ctrl",   2'd0, 32'h0);
        chk_rd("mr_load",   2'd1, 32'h0);
        chk_rd("mr_count",  2'd2, 32'h0);
        chk_rd("mr_status", 2'd3, 32'h0);
        cyc(); cyc(); cyc();
        chk_rd("mr_noexp", 2'd3, 32'h0);
        chk_irq("mr_irq", 1'b0);

`ifdef PERIPH_TIMER_PRESCALE_EN
        // PRESCALE=3, LOAD=2: expiry 8 cycles after enable
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h0301);
        chk_rd("ps_ctrl", 2'd0, 32'h0301);
        for (int i = 0; i < 7; i++) cyc();
        chk_rd("ps_pre", 2'd3, 32'h2);
        cyc();
        chk_rd("ps_exp", 2'd3, 32'h1);
`else
        // PRESCALE field is write-ignored
        wr(2'd0, 32'h0301);
        chk_rd("ps_ctrl_masked", 2'd0, 32'h0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/periph_timer.md
# periph_timer

Memory-mapped down-counting timer that acts as a responder on the peripheral port of the CPU data bus, behind the orbiter address decoder. The CPU programs it with load/store instructions through the chip-enable/write-enable/word-address interface and reads back count and status. The timer raises a level interrupt on expiry and supports one-shot and auto-reload modes.

## Interface
- No parameters; widths fixed: data 32 bits, register address 2 bits.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- CE  input  1  chip enable from orbiter; access targets this block
- PWE  input  1  write enable; write occurs when CE && PWE at rising clk
- addr  input  2  register word index
- wdata  input  32  write data (CPU store data)
- rdata  output  32  read data; combinational from addr when CE=1, else 0
- irq  output  1  interrupt, = STATUS.EXPIRED & CTRL.IE

## Operation
- Register map by addr: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
- CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE; bits [15:8] PRESCALE (see Configuration); other bits write-ignored, read 0.
- LOAD: 32-bit R/W reload value.
- COUNT: read current count; write forces count, overriding any decrement that cycle.
- STATUS: bit0 EXPIRED (sticky, write-1-to-clear), bit1 RUNNING (read-only, =1 in RUN); others read 0.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN: CTRL write with EN=1 while EN was 0; COUNT <= LOAD, prescale counter cleared.
- RUN with EN already 1: CTRL write with EN=1 only updates AUTO/IE/PRESCALE; no reload.
- RUN -> IDLE: CTRL write with EN=0; COUNT holds value.
- RUN, per tick: COUNT>1 -> COUNT-1. COUNT==1 -> EXPIRED<=1; AUTO=1: COUNT<=LOAD, stay RUN; AUTO=0: COUNT<=0, EN<=0, go DONE.
- RUN with COUNT==0 (LOAD=0 or COUNT written 0): next tick sets EXPIRED, COUNT stays 0, EN<=0, DONE regardless of AUTO.
- DONE behaves like IDLE except for state encoding; re-enable reloads.
- STATUS W1C in same cycle as expiry: set wins, EXPIRED=1.
- COUNT write same cycle as enable-reload: COUNT write wins.
- Reset: CTRL, LOAD, COUNT, STATUS = 0; state IDLE; prescale counter 0; irq = 0; rdata = 0 unless CE.

## Timing
- Writes take effect at the rising edge where CE && PWE; readback valid in following cycle.
- Reads: zero latency, combinational on addr/CE.
- Tick = every cycle without prescale. Enable at edge N, LOAD=L (L>=1): EXPIRED and irq high after edge N+L.
- Auto-reload period: L cycles between successive expiries.
- irq is a pure function of registered state; no glitch between edges.
- Reset asserted mid-count: all state cleared at that edge; no expiry reported.

## Configuration
- Macro PERIPH_TIMER_PRESCALE_EN.
- Defined: 8-bit prescale counter; tick issued when counter == CTRL.PRESCALE, then counter clears; enable-to-expiry = L*(PRESCALE+1) cycles. CTRL[15:8] R/W.
- Undefined: tick every cycle; CTRL[15:8] write-ignored, reads 0; no prescaler logic.

## Structure
- Package periph_timer_pkg: register address constants (CTRL/LOAD/COUNT/STATUS), CTRL and STATUS bit indices, PRESCALE field bounds, state enum {IDLE, RUN, DONE}.
- Sub-module periph_timer_prescaler: clk, reset, clear, divisor[7:0] -> tick; instantiated only under PERIPH_TIMER_PRESCALE_EN, else tick tied to 1.

## Test plan
- Reset: after reset, read all four addresses -> 0; irq=0; CE=0 -> rdata=0.
- One-shot: LOAD=5, CTRL=0x5 (EN, IE) at edge N -> COUNT reads 4,3,2,1 then EXPIRED=1, irq=1 after edge N+5; STATUS.RUNNING=0, CTRL.EN=0, COUNT=0.
- Auto-reload: LOAD=3, CTRL=0x3 -> EXPIRED set after N+3; W1C STATUS=1 clears; set again after N+6; COUNT reads 3 after each expiry.
- Collisions: STATUS W1C on expiry cycle -> EXPIRED stays 1; COUNT write of 10 on a tick cycle -> reads 10; CTRL EN=0 mid-count at COUNT=7 -> IDLE, COUNT=7 held; re-enable -> COUNT=LOAD.
- Edge: LOAD=0, enable -> EXPIRED after one tick, DONE, even with AUTO=1; reset asserted at COUNT=2 -> no expiry, all zero.
- Prescale (macro defined): PRESCALE=3, LOAD=2 -> expiry 8 cycles after enable; macro undefined: CTRL write 0x0301 reads back 0x0001.
